// File: rtl/load_store_unit.sv
// Load/store unit between the MIPS datapath and a word-addressed data memory.
// Sub-word loads are lane-extracted and extended; sub-word stores use read-modify-write.
module load_store_unit #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic [1:0]  size_q;
  logic        we_q, sign_q, err_q;
  logic        misaligned;

  // Bit offset of the addressed byte or halfword inside the memory word.
  function automatic logic [4:0] byte_shift(input logic [1:0] off);
    return BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
  endfunction

  function automatic logic [4:0] half_shift(input logic [1:0] off);
    return BIG_ENDIAN ? {~off[1], 4'b0000} : {off[1], 4'b0000};
  endfunction

  function automatic logic [31:0] load_format(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[byte_shift(off) +: 8];
    h = word[half_shift(off) +: 16];
    case (size)
      SZ_BYTE: return {{24{sgn & b[7]}}, b};
      SZ_HALF: return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] w;
    w = word;
    case (size)
      SZ_BYTE: w[byte_shift(off) +: 8]  = wd[7:0];
      SZ_HALF: w[half_shift(off) +: 16] = wd[15:0];
      default: w = wd;
    endcase
    return w;
  endfunction

  assign misaligned = (size_i == SZ_HALF && addr_i[0]) ||
                      (size_i == SZ_WORD && addr_i[1:0] != 2'b00) ||
                      (size_i == 2'b11);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the datapath registers are cleared too, so an abandoned access leaves no
      // stale address or write data on the memory interface.
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state_q)
        S_IDLE: begin
          err_q <= 1'b0;
          if (req_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            size_q  <= size_i;
            we_q    <= we_i;
            sign_q  <= sign_ext_i;
            rdata_q <= '0;
            if (misaligned) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else if (we_i && size_i == SZ_WORD) begin
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          word_q <= mem_rdata_i;
          if (we_q) begin
            state_q <= S_WR;
          end else begin
            rdata_q <= load_format(mem_rdata_i, addr_q[1:0], size_q, sign_q);
            state_q <= S_DONE;
          end
        end
        S_WR:    state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign mem_we_o    = (state_q == S_WR);
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o = store_merge(word_q, addr_q[1:0], size_q, wdata_q);

endmodule
